// File: rtl/tmds_lane_sequencer.sv
// tmds_lane_sequencer: divides x_clk into 10-cycle word slots and feeds one legal TMDS symbol per slot.
// Define TMDS_SEQ_AUX_EN to build the auxiliary packet path and its starvation guard.
module tmds_lane_sequencer #(
    parameter int unsigned PRE_LEN    = 8,
    parameter int unsigned GUARD_LEN  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       x_clk,
    input  logic       rst,
    input  logic [1:0] ctl_in,
    input  logic       vid_valid,
    input  logic [9:0] vid_word,
    output logic       vid_ready,
    input  logic       aux_valid,
    input  logic [9:0] aux_word,
    output logic       aux_ready,
    output logic [9:0] ser_word,
    output logic       ser_load,
    output logic       period_vid,
    output logic       period_aux
);

    localparam logic [2:0] ST_CTRL      = 3'd0;
    localparam logic [2:0] ST_PRE       = 3'd1;
    localparam logic [2:0] ST_GUARD     = 3'd2;
    localparam logic [2:0] ST_VID_DATA  = 3'd3;
`ifdef TMDS_SEQ_AUX_EN
    localparam logic [2:0] ST_AUX_DATA  = 3'd4;
    localparam logic [2:0] ST_AUX_TRAIL = 3'd5;
`endif

    localparam logic [9:0] CTL_00    = 10'b1101010100;
    localparam logic [9:0] CTL_01    = 10'b0010101011;
    localparam logic [9:0] CTL_10    = 10'b0101010100;
    localparam logic [9:0] CTL_11    = 10'b1010101011;
    localparam logic [9:0] VID_GUARD = 10'b1011001100;

    localparam logic [3:0] SLOT_LAST  = 4'd9;
    localparam logic [3:0] PRE_LAST   = 4'(PRE_LEN - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_LEN - 1);

`ifdef TMDS_SEQ_AUX_EN
    localparam logic [9:0] AUX_GUARD  = 10'b0100110011;
    localparam logic [3:0] TRAIL_LAST = 4'(GUARD_LEN - 2);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
`endif

    function automatic logic [9:0] ctl_code(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = CTL_00;
            2'b01:   w = CTL_01;
            2'b10:   w = CTL_10;
            default: w = CTL_11;
        endcase
        return w;
    endfunction

    logic [3:0] bit_cnt;
    logic       slot;
    logic [2:0] state;
    logic [2:0] state_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic [9:0] word_d;

`ifdef TMDS_SEQ_AUX_EN
    logic       tgt_aux;
    logic       tgt_aux_d;
    logic [3:0] aux_wait;
    logic [3:0] aux_wait_d;
    logic       force_aux;
`else
    logic       unused_aux;
    assign unused_aux = ^{aux_valid, aux_word};
    assign aux_ready  = 1'b0;
    assign period_aux = 1'b0;
`endif

    assign slot = (bit_cnt == SLOT_LAST);

`ifdef TMDS_SEQ_AUX_EN
    assign force_aux = aux_valid && (aux_wait >= STARVE_LIM);
`endif

    // Everything below is evaluated every cycle but only takes effect on a slot cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        word_d    = ser_word;
        vid_ready = 1'b0;
`ifdef TMDS_SEQ_AUX_EN
        tgt_aux_d  = tgt_aux;
        aux_wait_d = aux_wait;
        aux_ready  = 1'b0;
`endif
        if (slot && !rst) begin
            case (state)
                ST_CTRL: begin
                    word_d = ctl_code(ctl_in);
`ifdef TMDS_SEQ_AUX_EN
                    if (vid_valid && !force_aux) begin
                        state_d   = ST_PRE;
                        cnt_d     = '0;
                        tgt_aux_d = 1'b0;
                        if (aux_valid && (aux_wait != 4'hF)) begin
                            aux_wait_d = aux_wait + 4'd1;
                        end
                    end else if (aux_valid) begin
                        state_d    = ST_PRE;
                        cnt_d      = '0;
                        tgt_aux_d  = 1'b1;
                        aux_wait_d = '0;
                    end
`else
                    if (vid_valid) begin
                        state_d = ST_PRE;
                        cnt_d   = '0;
                    end
`endif
                end
                ST_PRE: begin
`ifdef TMDS_SEQ_AUX_EN
                    word_d = tgt_aux ? CTL_10 : CTL_01;
`else
                    word_d = CTL_01;
`endif
                    if (cnt == PRE_LAST) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                ST_GUARD: begin
`ifdef TMDS_SEQ_AUX_EN
                    word_d = tgt_aux ? AUX_GUARD : VID_GUARD;
`else
                    word_d = VID_GUARD;
`endif
                    if (cnt == GUARD_LAST) begin
`ifdef TMDS_SEQ_AUX_EN
                        state_d = tgt_aux ? ST_AUX_DATA : ST_VID_DATA;
`else
                        state_d = ST_VID_DATA;
`endif
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                ST_VID_DATA: begin
                    if (vid_valid) begin
                        vid_ready = 1'b1;
                        word_d    = vid_word;
                    end else begin
                        word_d  = ctl_code(ctl_in);
                        state_d = ST_CTRL;
                    end
                end
`ifdef TMDS_SEQ_AUX_EN
                ST_AUX_DATA: begin
                    if (aux_valid) begin
                        aux_ready = 1'b1;
                        word_d    = aux_word;
                    end else begin
                        // The closing slot is itself the first trailing guard word.
                        word_d  = AUX_GUARD;
                        state_d = (GUARD_LEN > 1) ? ST_AUX_TRAIL : ST_CTRL;
                        cnt_d   = '0;
                    end
                end
                ST_AUX_TRAIL: begin
                    word_d = AUX_GUARD;
                    if (cnt == TRAIL_LAST) begin
                        state_d = ST_CTRL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
`endif
                default: begin
                    word_d  = ctl_code(ctl_in);
                    state_d = ST_CTRL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge x_clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            state      <= ST_CTRL;
            cnt        <= '0;
            ser_word   <= CTL_00;
            ser_load   <= 1'b0;
            period_vid <= 1'b0;
        end else begin
            bit_cnt    <= slot ? 4'd0 : bit_cnt + 4'd1;
            state      <= state_d;
            cnt        <= cnt_d;
            ser_load   <= slot;
            period_vid <= (state_d == ST_VID_DATA);
            if (slot) begin
                ser_word <= word_d;
            end
        end
    end

`ifdef TMDS_SEQ_AUX_EN
    always_ff @(posedge x_clk) begin
        if (rst) begin
            tgt_aux    <= 1'b0;
            aux_wait   <= '0;
            period_aux <= 1'b0;
        end else begin
            tgt_aux    <= tgt_aux_d;
            aux_wait   <= aux_wait_d;
            period_aux <= (state_d == ST_AUX_DATA) || (state_d == ST_AUX_TRAIL);
        end
    end
`endif

endmodule

// File: tb/tb_tmds_lane_sequencer.sv
// Self-checking bench for tmds_lane_sequencer: queue-based word-slot model plus directed literal checks.
`timescale 1ns/1ps
module tb_tmds_lane_sequencer;

    localparam int unsigned PRE_LEN    = 8;
    localparam int unsigned GUARD_LEN  = 2;
    localparam int unsigned STARVE_MAX = 4;
`ifdef TMDS_SEQ_AUX_EN
    localparam bit AUX_EN = 1'b1;
`else
    localparam bit AUX_EN = 1'b0;
`endif

    localparam logic [9:0] CTL00  = 10'b1101010100;
    localparam logic [9:0] CTL01  = 10'b0010101011;
    localparam logic [9:0] CTL10  = 10'b0101010100;
    localparam logic [9:0] CTL11  = 10'b1010101011;
    localparam logic [9:0] VGUARD = 10'b1011001100;
    localparam logic [9:0] AGUARD = 10'b0100110011;

    logic       x_clk = 1'b0;
    logic       rst;
    logic [1:0] ctl_in;
    logic       vid_valid, aux_valid;
    logic [9:0] vid_word, aux_word;
    logic       vid_ready, aux_ready;
    logic [9:0] ser_word;
    logic       ser_load, period_vid, period_aux;

    always #5 x_clk = ~x_clk;

    tmds_lane_sequencer #(
        .PRE_LEN   (PRE_LEN),
        .GUARD_LEN (GUARD_LEN),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .x_clk     (x_clk),
        .rst       (rst),
        .ctl_in    (ctl_in),
        .vid_valid (vid_valid),
        .vid_word  (vid_word),
        .vid_ready (vid_ready),
        .aux_valid (aux_valid),
        .aux_word  (aux_word),
        .aux_ready (aux_ready),
        .ser_word  (ser_word),
        .ser_load  (ser_load),
        .period_vid(period_vid),
        .period_aux(period_aux)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ctl_word(input logic [1:0] c);
        case (c)
            2'b00:   return CTL00;
            2'b01:   return CTL01;
            2'b10:   return CTL10;
            default: return CTL11;
        endcase
    endfunction

    // Model: a grant schedules the whole lead-in as a word queue; data kinds 0=none 1=video 2=aux.
    logic [9:0] m_lead[$];
    int         m_after;
    int         m_data;
    bit         m_trail;
    int         m_wait;

    task automatic m_reset();
        m_lead.delete();
        m_after = 0;
        m_data  = 0;
        m_trail = 1'b0;
        m_wait  = 0;
    endtask

    task automatic m_step(input logic [1:0] c, input logic vv, input logic [9:0] vw,
                          input logic av, input logic [9:0] aw,
                          output logic [9:0] w, output bit vr, output bit ar);
        bit aux_on;
        vr = 1'b0;
        ar = 1'b0;
        w  = ctl_word(c);
        if (m_lead.size() != 0) begin
            w = m_lead.pop_front();
            if (m_lead.size() == 0) begin
                m_data  = m_after;
                m_trail = 1'b0;
            end
        end else if (m_data == 1) begin
            if (vv) begin
                w  = vw;
                vr = 1'b1;
            end else begin
                m_data = 0;
            end
        end else if (m_data == 2) begin
            if (av) begin
                w  = aw;
                ar = 1'b1;
            end else begin
                w      = AGUARD;
                m_data = 0;
                for (int i = 1; i < int'(GUARD_LEN); i++) m_lead.push_back(AGUARD);
                m_after = 0;
                m_trail = (m_lead.size() != 0);
            end
        end else begin
            aux_on = AUX_EN && av;
            if (vv && !(aux_on && m_wait >= int'(STARVE_MAX))) begin
                if (aux_on) m_wait = (m_wait >= 15) ? 15 : m_wait + 1;
                for (int i = 0; i < int'(PRE_LEN); i++) m_lead.push_back(CTL01);
                for (int i = 0; i < int'(GUARD_LEN); i++) m_lead.push_back(VGUARD);
                m_after = 1;
            end else if (aux_on) begin
                m_wait = 0;
                for (int i = 0; i < int'(PRE_LEN); i++) m_lead.push_back(CTL10);
                for (int i = 0; i < int'(GUARD_LEN); i++) m_lead.push_back(AGUARD);
                m_after = 2;
            end
        end
    endtask

    // Compare process: expectations are for the values that follow the next rising edge.
    bit         armed = 1'b0;
    int         phase = 0;
    logic [9:0] e_word;
    bit         e_load, e_pv, e_pa;
    logic [9:0] seen[$];
    int         starts[$];
    int         vr_pulses = 0, ar_pulses = 0, pa_count = 0;
    bit         prev_pv = 1'b0, prev_pa = 1'b0;

    always @(negedge x_clk) begin
        logic [9:0] w;
        bit vr, ar;
        if (armed) begin
            chk("ser_word", ser_word, e_word);
            chk("ser_load", ser_load, e_load);
            chk("period_vid", period_vid, e_pv);
            chk("period_aux", period_aux, e_pa);
            if (ser_load) seen.push_back(ser_word);
            if (period_vid && !prev_pv) starts.push_back(1);
            if (period_aux && !prev_pa) starts.push_back(2);
            if (period_aux) pa_count++;
            prev_pv = period_vid;
            prev_pa = period_aux;
        end
        vr = 1'b0;
        ar = 1'b0;
        w  = e_word;
        if (!rst && phase == 9) m_step(ctl_in, vid_valid, vid_word, aux_valid, aux_word, w, vr, ar);
        if (armed) begin
            chk("vid_ready", vid_ready, vr);
            chk("aux_ready", aux_ready, ar);
            if (vid_ready) vr_pulses++;
            if (aux_ready) ar_pulses++;
        end
        if (rst) begin
            m_reset();
            phase  = 0;
            e_word = CTL00;
            e_load = 1'b0;
            e_pv   = 1'b0;
            e_pa   = 1'b0;
            armed  = 1'b1;
        end else begin
            e_load = (phase == 9);
            if (phase == 9) begin
                e_word = w;
                e_pv   = (m_data == 1);
                e_pa   = (m_data == 2) || m_trail;
            end
            phase = (phase == 9) ? 0 : phase + 1;
        end
    end

    // Sources hold valid and word until accepted, then pause for a gap before the next burst.
    bit         v_en = 1'b0, a_en = 1'b0, rnd_ctl = 1'b0;
    int         v_left = 0, a_left = 0, v_gap = 0, a_gap = 0;
    int         b_min = 1, b_max = 1, g_min = 1, g_max = 1;
    logic [9:0] v_sent[$], a_sent[$];

    task automatic tick();
        bit acc_v, acc_a;
        @(negedge x_clk);
        acc_v = vid_valid && vid_ready;
        acc_a = aux_valid && aux_ready;
        @(posedge x_clk);
        #1;
        if (acc_v) begin
            v_left--;
            if (v_left <= 0) begin
                vid_valid = 1'b0;
                v_gap     = $urandom_range(g_min, g_max);
            end else begin
                vid_word = 10'($urandom);
                v_sent.push_back(vid_word);
            end
        end else if (!vid_valid && v_en) begin
            if (v_gap > 0) v_gap--;
            if (v_gap == 0) begin
                vid_valid = 1'b1;
                vid_word  = 10'($urandom);
                v_sent.push_back(vid_word);
                v_left = $urandom_range(b_min, b_max);
            end
        end
        if (acc_a) begin
            a_left--;
            if (a_left <= 0) begin
                aux_valid = 1'b0;
                a_gap     = $urandom_range(g_min, g_max);
            end else begin
                aux_word = 10'($urandom);
                a_sent.push_back(aux_word);
            end
        end else if (!aux_valid && a_en) begin
            if (a_gap > 0) a_gap--;
            if (a_gap == 0) begin
                aux_valid = 1'b1;
                aux_word  = 10'($urandom);
                a_sent.push_back(aux_word);
                a_left = $urandom_range(b_min, b_max);
            end
        end
        if (rnd_ctl && $urandom_range(0, 7) == 0) ctl_in = 2'($urandom_range(0, 3));
    endtask

    function automatic int first_non(input logic [9:0] w);
        for (int i = 0; i < seen.size(); i++) if (seen[i] != w) return i;
        return -1;
    endfunction

    initial begin
        int first, bad, i, n;
        bit hit;
        int pat[10];
        rst = 1'b1; ctl_in = 2'b11;
        vid_valid = 1'b0; vid_word = '0; aux_valid = 1'b0; aux_word = '0;
        repeat (3) tick();
        rst = 1'b0;

        first = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ser_load && first == 0) first = k;
        end
        chk("first_load_cycle", first, 10);
        seen.delete(); vr_pulses = 0; ar_pulses = 0;
        repeat (60) tick();
        chk("idle_load_count", seen.size(), 6);
        bad = 0;
        foreach (seen[k]) if (seen[k] != CTL11) bad++;
        chk("idle_words", bad, 0);
        chk("idle_ready_pulses", vr_pulses + ar_pulses, 0);

        ctl_in = 2'b00; seen.delete(); vr_pulses = 0; v_sent.delete();
        b_min = 3; b_max = 3; g_min = 1000; g_max = 1000; v_gap = 0; v_en = 1'b1;
        repeat (200) tick();
        v_en = 1'b0;
        i = first_non(CTL00);
        if (i < 0 || i + 14 > seen.size() || v_sent.size() < 3) chk("vid_burst_found", 0, 1);
        else begin
            for (int j = 0; j < 8; j++) chk("vid_preamble", seen[i+j], CTL01);
            for (int j = 8; j < 10; j++) chk("vid_guard", seen[i+j], VGUARD);
            for (int j = 0; j < 3; j++) chk("vid_data", seen[i+10+j], v_sent[j]);
            chk("vid_tail_ctl", seen[i+13], CTL00);
        end
        chk("vid_ready_pulses", vr_pulses, 3);

`ifdef TMDS_SEQ_AUX_EN
        seen.delete(); ar_pulses = 0; a_sent.delete();
        b_min = 2; b_max = 2; a_gap = 0; a_en = 1'b1;
        repeat (200) tick();
        a_en = 1'b0;
        i = first_non(CTL00);
        if (i < 0 || i + 15 > seen.size() || a_sent.size() < 2) chk("aux_burst_found", 0, 1);
        else begin
            for (int j = 0; j < 8; j++) chk("aux_preamble", seen[i+j], CTL10);
            for (int j = 8; j < 10; j++) chk("aux_guard", seen[i+j], AGUARD);
            for (int j = 0; j < 2; j++) chk("aux_data", seen[i+10+j], a_sent[j]);
            for (int j = 12; j < 14; j++) chk("aux_trail", seen[i+j], AGUARD);
            chk("aux_tail_ctl", seen[i+14], CTL00);
        end
        chk("aux_ready_pulses", ar_pulses, 2);

        rst = 1'b1; repeat (2) tick(); rst = 1'b0;
        starts.delete();
        b_min = 1; b_max = 1; g_min = 12; g_max = 12; v_gap = 0; a_gap = 0;
        v_en = 1'b1; a_en = 1'b1;
        n = 0;
        while (starts.size() < 10 && n < 4000) begin tick(); n++; end
        v_en = 1'b0; a_en = 1'b0;
        pat = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        if (starts.size() < 10) chk("starve_timeout", starts.size(), 10);
        else for (int j = 0; j < 10; j++) chk("starve_order", starts[j], pat[j]);
        repeat (400) tick();
`else
        seen.delete(); ar_pulses = 0; pa_count = 0;
        b_min = 1; b_max = 1; a_gap = 0; a_en = 1'b1;
        repeat (200) tick();
        chk("noaux_load_count", seen.size(), 20);
        bad = 0;
        foreach (seen[k]) if (seen[k] != CTL00) bad++;
        chk("noaux_words", bad, 0);
        chk("noaux_ready_pulses", ar_pulses, 0);
        chk("noaux_period_aux", pa_count, 0);
        a_en = 1'b0;
`endif

        b_min = 50; b_max = 50; g_min = 1000; g_max = 1000; v_gap = 0; v_en = 1'b1;
        n = 0; hit = 1'b0;
        while (!hit && n < 600) begin
            tick(); n++;
            if (period_vid && phase == 5) hit = 1'b1;
        end
        if (hit) begin
            rst = 1'b1; v_left = 1; v_en = 1'b0;
            @(posedge x_clk);
            @(negedge x_clk);
            chk("rst_mid_load", ser_load, 0);
            chk("rst_mid_word", ser_word, CTL00);
            chk("rst_mid_pvid", period_vid, 0);
            tick();
            rst = 1'b0;
        end else begin
            chk("rst_wait_timeout", 0, 1);
            v_en = 1'b0; v_left = 1;
        end
        repeat (300) tick();

        rnd_ctl = 1'b1; b_min = 1; b_max = 4; g_min = 1; g_max = 40;
        v_en = 1'b1; a_en = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 599) == 0) rst = 1'b1;
        end
        rst = 1'b0; v_en = 1'b0; a_en = 1'b0; rnd_ctl = 1'b0;
        repeat (600) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
